// File: rtl/controle_multiciclo.sv
// Multi-cycle RISC-V control unit: decodes opcode/funct3/funct7 latched at fetch
// and sequences FETCH/DECODE/EXEC/MEM/WB with a bounded memory-ready wait.
module controle_multiciclo #(
  parameter int ALUCTRL_W    = 4,
  parameter bit ENABLE_LOGIC = 1'b1,
  parameter bit ENABLE_BNE   = 1'b1,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 instr_ready,
  output logic                 pcwrite,
  output logic                 branch_taken,
  output logic                 regwrite,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 memtoreg,
  output logic                 alusrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic                 mem_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_ILL   = 3'd0,
    C_LW    = 3'd1,
    C_SW    = 3'd2,
    C_ADDI  = 3'd3,
    C_RTYPE = 3'd4,
    C_BEQ   = 3'd5,
    C_BNE   = 3'd6
  } cls_t;

  function automatic cls_t decode_cls(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
    cls_t c;
    c = C_ILL;
    case (op)
      7'b0000011: c = (f3 == 3'b010) ? C_LW : C_ILL;
      7'b0010011: c = (f3 == 3'b000) ? C_ADDI : C_ILL;
      7'b0100011: c = (f3 == 3'b010) ? C_SW : C_ILL;
      7'b0110011: begin
        case (f3)
          3'b000:                c = (f7 == 7'b0000000 || f7 == 7'b0100000) ? C_RTYPE : C_ILL;
          3'b100, 3'b110, 3'b111: c = (ENABLE_LOGIC && f7 == 7'b0000000) ? C_RTYPE : C_ILL;
          3'b101:                c = (f7 == 7'b0000000) ? C_RTYPE : C_ILL;
          default:               c = C_ILL;
        endcase
      end
      7'b1100011: begin
        case (f3)
          3'b000:  c = C_BEQ;
          3'b001:  c = ENABLE_BNE ? C_BNE : C_ILL;
          default: c = C_ILL;
        endcase
      end
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  // R-type op selects by funct3 (funct7[5] splits add/sub); branches compare via sub
  function automatic logic [3:0] alu_code(input cls_t c, input logic [2:0] f3,
                                          input logic [6:0] f7);
    logic [3:0] a;
    a = 4'b0010;
    case (c)
      C_RTYPE: begin
        case (f3)
          3'b000:  a = f7[5] ? 4'b0110 : 4'b0010;
          3'b100:  a = 4'b0011;
          3'b110:  a = 4'b0001;
          3'b111:  a = 4'b0000;
          3'b101:  a = 4'b0101;
          default: a = 4'b0010;
        endcase
      end
      C_BEQ, C_BNE: a = 4'b0110;
      default:      a = 4'b0010;
    endcase
    return a;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [6:0]         op_r, f7_r;
  logic [2:0]         f3_r;
  logic [CNT_W-1:0]   cnt_r;
  cls_t               cls_s;
  logic [3:0]         alu_s, alu4_s;
  logic               cnt_max_s, is_mem_cls_s;
  logic               instr_ready_s, pcwrite_s, branch_taken_s, regwrite_s, memread_s;
  logic               memwrite_s, memtoreg_s, alusrc_s, illegal_s, mem_error_s;

  assign cls_s        = decode_cls(op_r, f3_r, f7_r);
  assign alu_s        = alu_code(cls_s, f3_r, f7_r);
  assign cnt_max_s    = (cnt_r == CNT_W'(MEM_WAIT_MAX));
  assign is_mem_cls_s = (cls_s == C_LW) || (cls_s == C_SW) || (cls_s == C_ADDI);

  // State register, fetched-field latch and MEM wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
      op_r    <= 7'd0;
      f3_r    <= 3'd0;
      f7_r    <= 7'd0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == S_FETCH && instr_valid) begin
        op_r <= opcode;
        f3_r <= funct3;
        f7_r <= funct7;
      end
      if (state_r == S_EXEC) begin
        cnt_r <= '0;
      end else if (state_r == S_MEM && !mem_ready && !cnt_max_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_nxt_s    = state_r;
    instr_ready_s  = 1'b0;
    pcwrite_s      = 1'b0;
    branch_taken_s = 1'b0;
    regwrite_s     = 1'b0;
    memread_s      = 1'b0;
    memwrite_s     = 1'b0;
    memtoreg_s     = 1'b0;
    alusrc_s       = 1'b0;
    alu4_s         = 4'b0000;
    illegal_s      = 1'b0;
    mem_error_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        instr_ready_s = 1'b1;
        state_nxt_s   = instr_valid ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        if (cls_s == C_ILL) begin
          illegal_s   = 1'b1;
          pcwrite_s   = 1'b1;
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_EXEC;
        end
      end
      S_EXEC: begin
        alu4_s   = alu_s;
        alusrc_s = is_mem_cls_s;
        case (cls_s)
          C_LW, C_SW:      state_nxt_s = S_MEM;
          C_RTYPE, C_ADDI: state_nxt_s = S_WB;
          C_BEQ: begin
            pcwrite_s      = 1'b1;
            branch_taken_s = zero;
            state_nxt_s    = S_FETCH;
          end
          C_BNE: begin
            pcwrite_s      = 1'b1;
            branch_taken_s = !zero;
            state_nxt_s    = S_FETCH;
          end
          default: state_nxt_s = S_FETCH;
        endcase
      end
      S_MEM: begin
        memread_s  = (cls_s == C_LW);
        memwrite_s = (cls_s == C_SW);
        alusrc_s   = 1'b1;
        alu4_s     = 4'b0010;
        // ready takes priority over the timeout on the limit cycle
        if (mem_ready) begin
          if (cls_s == C_LW) begin
            state_nxt_s = S_WB;
          end else begin
            pcwrite_s   = 1'b1;
            state_nxt_s = S_FETCH;
          end
        end else if (cnt_max_s) begin
          mem_error_s = 1'b1;
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB: begin
        regwrite_s  = 1'b1;
        pcwrite_s   = 1'b1;
        memtoreg_s  = (cls_s == C_LW);
        alu4_s      = alu_s;
        alusrc_s    = is_mem_cls_s;
        state_nxt_s = S_FETCH;
      end
      default: state_nxt_s = S_FETCH;
    endcase
  end

  // Reset forces every output low even before the first reset edge lands
  assign instr_ready  = rst_n & instr_ready_s;
  assign pcwrite      = rst_n & pcwrite_s;
  assign branch_taken = rst_n & branch_taken_s;
  assign regwrite     = rst_n & regwrite_s;
  assign memread      = rst_n & memread_s;
  assign memwrite     = rst_n & memwrite_s;
  assign memtoreg     = rst_n & memtoreg_s;
  assign alusrc       = rst_n & alusrc_s;
  assign alucontrol   = rst_n ? ALUCTRL_W'(alu4_s) : '0;
  assign illegal      = rst_n & illegal_s;
  assign mem_error    = rst_n & mem_error_s;
  assign busy         = rst_n & (state_r != S_FETCH);

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: default instance plus a second one with
// MEM_WAIT_MAX=3 and logic/bne decoding disabled.
module tb_controle_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic a_ir, a_pc, a_bt, a_rw, a_mr, a_mw, a_mtr, a_as, a_ill, a_me, a_bz;
  logic b_ir, b_pc, b_bt, b_rw, b_mr, b_mw, b_mtr, b_as, b_ill, b_me, b_bz;
  logic [3:0] a_alu, b_alu;
  logic [14:0] va, vb;

  int total = 0;
  int bad = 0;

  localparam logic [14:0] IDLE = 15'b100000000000000;
  localparam logic [14:0] DEC  = 15'b000000000000001;
  localparam logic [14:0] ZERO = 15'b000000000000000;

  always #5 clk = ~clk;

  controle_multiciclo dut_a (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .zero(zero), .mem_ready(mem_ready),
    .instr_ready(a_ir), .pcwrite(a_pc), .branch_taken(a_bt), .regwrite(a_rw),
    .memread(a_mr), .memwrite(a_mw), .memtoreg(a_mtr), .alusrc(a_as),
    .alucontrol(a_alu), .illegal(a_ill), .mem_error(a_me), .busy(a_bz)
  );

  controle_multiciclo #(
    .ALUCTRL_W(4), .ENABLE_LOGIC(1'b0), .ENABLE_BNE(1'b0), .MEM_WAIT_MAX(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .zero(zero), .mem_ready(mem_ready),
    .instr_ready(b_ir), .pcwrite(b_pc), .branch_taken(b_bt), .regwrite(b_rw),
    .memread(b_mr), .memwrite(b_mw), .memtoreg(b_mtr), .alusrc(b_as),
    .alucontrol(b_alu), .illegal(b_ill), .mem_error(b_me), .busy(b_bz)
  );

  assign va = {a_ir, a_pc, a_bt, a_rw, a_mr, a_mw, a_mtr, a_as, a_alu, a_ill, a_me, a_bz};
  assign vb = {b_ir, b_pc, b_bt, b_rw, b_mr, b_mw, b_mtr, b_as, b_alu, b_ill, b_me, b_bz};

  function automatic logic [14:0] ev(input logic ir, pc, bt, rw, mr, mw, mtr, as,
                                     input logic [3:0] alu, input logic ill, me, bz);
    return {ir, pc, bt, rw, mr, mw, mtr, as, alu, ill, me, bz};
  endfunction

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic ca(input string tag, input logic [14:0] e);
    #1;
    total++;
    assert (va === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, va, e);
    end
  endtask

  task automatic cb(input string tag, input logic [14:0] e);
    #1;
    total++;
    assert (vb === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, vb, e);
    end
  endtask

  task automatic chk(input bit on_b, input string tag, input logic [14:0] e);
    if (on_b) cb(tag, e);
    else ca(tag, e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    go();
    ca("rst_a", ZERO);
    cb("rst_b", ZERO);
    go();
    rst_n = 1'b1;
    ca("rst_rel_a", IDLE);
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input bit on_b);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    instr_valid = 1'b1;
    chk(on_b, "accept", IDLE);
    go();
    instr_valid = 1'b0;
  endtask

  task automatic run_r(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [3:0] alu, input logic as);
    issue(op, f3, f7, 1'b0);
    ca({tag, "_dec"}, DEC);
    go();
    ca({tag, "_exec"}, ev(0, 0, 0, 0, 0, 0, 0, as, alu, 0, 0, 1));
    go();
    ca({tag, "_wb"}, ev(0, 1, 0, 1, 0, 0, 0, as, alu, 0, 0, 1));
    go();
    ca({tag, "_done"}, IDLE);
  endtask

  task automatic mem_run(input string tag, input bit lw, input int waits, input bit on_b);
    issue(lw ? 7'b0000011 : 7'b0100011, 3'b010, 7'd0, on_b);
    chk(on_b, {tag, "_dec"}, DEC);
    go();
    chk(on_b, {tag, "_exec"}, ev(0, 0, 0, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 1));
    go();
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      chk(on_b, {tag, "_wait"}, ev(0, 0, 0, 0, lw, !lw, 0, 1, 4'b0010, 0, 0, 1));
      go();
    end
    mem_ready = 1'b1;
    chk(on_b, {tag, "_ready"}, ev(0, !lw, 0, 0, lw, !lw, 0, 1, 4'b0010, 0, 0, 1));
    go();
    mem_ready = 1'b0;
    if (lw) begin
      chk(on_b, {tag, "_wb"}, ev(0, 1, 0, 1, 0, 0, 1, 1, 4'b0010, 0, 0, 1));
      go();
    end
    chk(on_b, {tag, "_done"}, IDLE);
  endtask

  task automatic br(input string tag, input logic [2:0] f3, input logic z, input logic bt);
    issue(7'b1100011, f3, 7'd0, 1'b0);
    ca({tag, "_dec"}, DEC);
    go();
    zero = z;
    ca({tag, "_exec"}, ev(0, 1, bt, 0, 0, 0, 0, 0, 4'b0110, 0, 0, 1));
    go();
    zero = 1'b0;
    ca({tag, "_done"}, IDLE);
  endtask

  initial begin
    do_reset();

    run_r("add",  7'b0110011, 3'b000, 7'b0000000, 4'b0010, 1'b0);
    run_r("sub",  7'b0110011, 3'b000, 7'b0100000, 4'b0110, 1'b0);
    run_r("srl",  7'b0110011, 3'b101, 7'b0000000, 4'b0101, 1'b0);
    run_r("xor",  7'b0110011, 3'b100, 7'b0000000, 4'b0011, 1'b0);
    run_r("or",   7'b0110011, 3'b110, 7'b0000000, 4'b0001, 1'b0);
    run_r("and",  7'b0110011, 3'b111, 7'b0000000, 4'b0000, 1'b0);
    run_r("addi", 7'b0010011, 3'b000, 7'b1010101, 4'b0010, 1'b1);

    // srl encoding with the sub funct7 is not decodable
    issue(7'b0110011, 3'b101, 7'b0100000, 1'b0);
    ca("ill_srl", ev(0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 1));
    go();
    ca("ill_srl_done", IDLE);
    issue(7'b1111111, 3'b000, 7'd0, 1'b0);
    ca("ill_op", ev(0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 1));
    go();
    ca("ill_op_done", IDLE);

    mem_run("lw3", 1'b1, 3, 1'b0);
    mem_run("sw3", 1'b0, 3, 1'b0);
    mem_run("lw0", 1'b1, 0, 1'b0);

    br("beq_z1", 3'b000, 1'b1, 1'b1);
    br("beq_z0", 3'b000, 1'b0, 1'b0);
    br("bne_z1", 3'b001, 1'b1, 1'b0);
    br("bne_z0", 3'b001, 1'b0, 1'b1);

    // reset while waiting in MEM aborts the load
    issue(7'b0000011, 3'b010, 7'd0, 1'b0);
    go();
    go();
    ca("rmem_mem", ev(0, 0, 0, 0, 1, 0, 0, 1, 4'b0010, 0, 0, 1));
    rst_n = 1'b0;
    ca("rmem_low", ZERO);
    go();
    rst_n = 1'b1;
    ca("rmem_fetch", IDLE);

    // timeout on the MEM_WAIT_MAX=3 instance
    do_reset();
    issue(7'b0000011, 3'b010, 7'd0, 1'b1);
    cb("to_dec", DEC);
    go();
    cb("to_exec", ev(0, 0, 0, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 1));
    go();
    for (int i = 0; i < 3; i++) begin
      cb("to_wait", ev(0, 0, 0, 0, 1, 0, 0, 1, 4'b0010, 0, 0, 1));
      go();
    end
    cb("to_err", ev(0, 0, 0, 0, 1, 0, 0, 1, 4'b0010, 0, 1, 1));
    go();
    cb("to_done", IDLE);

    // ready arriving exactly on the limit cycle completes normally
    do_reset();
    mem_run("lim_lw", 1'b1, 3, 1'b1);
    do_reset();
    mem_run("lim_sw", 1'b0, 3, 1'b1);

    do_reset();
    issue(7'b0110011, 3'b100, 7'd0, 1'b1);
    cb("b_xor_ill", ev(0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 1));
    ca("a_xor_dec", DEC);
    go();
    cb("b_xor_done", IDLE);

    do_reset();
    issue(7'b1100011, 3'b001, 7'd0, 1'b1);
    cb("b_bne_ill", ev(0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 1));
    ca("a_bne_dec", DEC);
    go();
    cb("b_bne_done", IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
